// File: rtl/tx_byte_scheduler.sv
// Bit-rate TX byte scheduler: comma preamble after reset, then arbitrates two byte lanes into the
// serializer one 8-bit frame at a time. Define TX_STRICT_PRIORITY_EN for fixed lane-0 priority.
module tx_byte_scheduler #(
  parameter int unsigned COMMA_COUNT = 4,
  parameter logic [7:0]  IDLE_BYTE   = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       tx_enable,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [2:0] bit_idx,
  output logic       frame_start,
  output logic       link_ready,
  output logic       lane_sel
);

  localparam logic       StInit    = 1'b0;
  localparam logic       StRun     = 1'b1;
  localparam logic [3:0] CommaLast = 4'(COMMA_COUNT - 1);

  logic       state_q, state_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_q, valid_d;
  logic       lane_sel_q, lane_sel_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       link_ready_q, link_ready_d;
`ifndef TX_STRICT_PRIORITY_EN
  logic       rr_last_q, rr_last_d;
`endif

  logic load, arb, el0, el1, pick1;

  assign el0 = tx_enable & req0;
  assign el1 = tx_enable & req1;
`ifdef TX_STRICT_PRIORITY_EN
  assign pick1 = el1 & ~el0;
`else
  // On contention the lane that did not win last time gets the slot.
  assign pick1 = el1 & (~el0 | ~rr_last_q);
`endif

  always_comb begin
    state_d      = state_q;
    comma_cnt_d  = comma_cnt_q;
    bit_idx_d    = bit_idx_q + 3'd1;
    data_out_d   = data_out_q;
    valid_d      = valid_q;
    lane_sel_d   = lane_sel_q;
    link_ready_d = link_ready_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
`ifndef TX_STRICT_PRIORITY_EN
    rr_last_d    = rr_last_q;
`endif
    load = (bit_idx_q == 3'd7);
    arb  = 1'b0;

    if (load) begin
      if (state_q == StInit) begin
        comma_cnt_d = comma_cnt_q + 4'd1;
        // Last comma frame: the first data byte is chosen on this same edge.
        if (comma_cnt_q == CommaLast) begin
          state_d      = StRun;
          link_ready_d = 1'b1;
          arb          = 1'b1;
        end
      end else begin
        arb = 1'b1;
      end
    end

    if (arb) begin
      if (el0 | el1) begin
        data_out_d = pick1 ? data1 : data0;
        valid_d    = 1'b1;
        lane_sel_d = pick1;
        gnt0_d     = ~pick1;
        gnt1_d     = pick1;
`ifndef TX_STRICT_PRIORITY_EN
        rr_last_d  = pick1;
`endif
      end else begin
        data_out_d = IDLE_BYTE;
        valid_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= StInit;
      comma_cnt_q  <= 4'd0;
      bit_idx_q    <= 3'd0;
      data_out_q   <= IDLE_BYTE;
      valid_q      <= 1'b0;
      lane_sel_q   <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      link_ready_q <= 1'b0;
`ifndef TX_STRICT_PRIORITY_EN
      rr_last_q    <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      comma_cnt_q  <= comma_cnt_d;
      bit_idx_q    <= bit_idx_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      lane_sel_q   <= lane_sel_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      link_ready_q <= link_ready_d;
`ifndef TX_STRICT_PRIORITY_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign data_out    = data_out_q;
  assign valid_out   = valid_q;
  assign bit_idx     = bit_idx_q;
  assign frame_start = (bit_idx_q == 3'd0);
  assign link_ready  = link_ready_q;
  assign lane_sel    = lane_sel_q;

endmodule

// File: tb/tb_tx_byte_scheduler.sv
// Directed self-checking bench for tx_byte_scheduler (COMMA_COUNT=4, IDLE_BYTE=0xBC).
module tb_tx_byte_scheduler;

  logic       clk_32f = 1'b0;
  logic       reset_L;
  logic       tx_enable;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, valid_out, frame_start, link_ready, lane_sel;
  logic [7:0] data_out;
  logic [2:0] bit_idx;

  int n_tests = 0;
  int n_fail  = 0;

  tx_byte_scheduler #(
    .COMMA_COUNT(4),
    .IDLE_BYTE  (8'hBC)
  ) dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .tx_enable  (tx_enable),
    .req0       (req0),
    .data0      (data0),
    .req1       (req1),
    .data1      (data1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .bit_idx    (bit_idx),
    .frame_start(frame_start),
    .link_ready (link_ready),
    .lane_sel   (lane_sel)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // One clock edge, sampled 1ns later; grant pulses must be one-hot and only at bit_idx 0.
  task automatic tick();
    @(posedge clk_32f);
    #1;
    chk1("gnt_onehot", gnt0 & gnt1, 1'b0);
    chk1("gnt_only_at_idx0", (gnt0 | gnt1) && (bit_idx != 3'd0), 1'b0);
  endtask

  task automatic reset_vals(input string tag);
    chk8({tag, "_bit_idx"}, {5'd0, bit_idx}, 8'd0);
    chk8({tag, "_data_out"}, data_out, 8'hBC);
    chk1({tag, "_valid"}, valid_out, 1'b0);
    chk1({tag, "_gnt0"}, gnt0, 1'b0);
    chk1({tag, "_gnt1"}, gnt1, 1'b0);
    chk1({tag, "_link_ready"}, link_ready, 1'b0);
    chk1({tag, "_lane_sel"}, lane_sel, 1'b0);
    chk1({tag, "_frame_start"}, frame_start, 1'b1);
  endtask

  // Advance one whole frame and check what the load edge presented.
  task automatic frame(input string tag, input logic g0, input logic g1, input logic [7:0] d,
                       input logic v, input logic ln);
    repeat (8) tick();
    chk8({tag, "_bit_idx"}, {5'd0, bit_idx}, 8'd0);
    chk1({tag, "_frame_start"}, frame_start, 1'b1);
    chk1({tag, "_gnt0"}, gnt0, g0);
    chk1({tag, "_gnt1"}, gnt1, g1);
    chk8({tag, "_data"}, data_out, d);
    chk1({tag, "_valid"}, valid_out, v);
    if (v) chk1({tag, "_lane_sel"}, lane_sel, ln);
  endtask

  initial begin
    reset_L   = 1'b0;
    tx_enable = 1'b1;
    req0      = 1'b1;
    data0     = 8'hA5;
    req1      = 1'b0;
    data1     = 8'h00;
    repeat (3) @(posedge clk_32f);
    #1;
    reset_vals("por");

    // Preamble: req0 held from reset must not be granted before edge 32.
    @(negedge clk_32f);
    reset_L = 1'b1;
    for (int e = 1; e < 32; e++) begin
      tick();
      chk8("pre_bit_idx", {5'd0, bit_idx}, 8'(e % 8));
      chk1("pre_frame_start", frame_start, (e % 8) == 0);
      chk8("pre_data", data_out, 8'hBC);
      chk1("pre_valid", valid_out, 1'b0);
      chk1("pre_gnt0", gnt0, 1'b0);
      chk1("pre_link_ready", link_ready, 1'b0);
    end
    tick();
    chk1("e32_link_ready", link_ready, 1'b1);
    chk1("e32_gnt0", gnt0, 1'b1);
    chk1("e32_gnt1", gnt1, 1'b0);
    chk8("e32_data", data_out, 8'hA5);
    chk1("e32_valid", valid_out, 1'b1);
    chk1("e32_lane_sel", lane_sel, 1'b0);
    req0 = 1'b0;
    for (int e = 33; e < 40; e++) begin
      tick();
      chk8("hold_a5_data", data_out, 8'hA5);
      chk1("hold_a5_valid", valid_out, 1'b1);
      chk1("hold_a5_gnt0", gnt0, 1'b0);
    end
    tick();
    chk8("after_a5_data", data_out, 8'hBC);
    chk1("after_a5_valid", valid_out, 1'b0);
    chk1("after_a5_gnt0", gnt0, 1'b0);

    // Both lanes requesting continuously; lane 0 won last, so lane 1 goes first.
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 8'h11;
    data1 = 8'h22;
`ifdef TX_STRICT_PRIORITY_EN
    frame("both_f0", 1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
    frame("both_f1", 1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
    frame("both_f2", 1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
    frame("both_f3", 1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
`else
    frame("both_f0", 1'b0, 1'b1, 8'h22, 1'b1, 1'b1);
    frame("both_f1", 1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
    frame("both_f2", 1'b0, 1'b1, 8'h22, 1'b1, 1'b1);
    frame("both_f3", 1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
`endif

    // Lane 0 drops; tx_enable low blocks lane 1 until re-raised.
    req0      = 1'b0;
    tx_enable = 1'b0;
    frame("txdis_f0", 1'b0, 1'b0, 8'hBC, 1'b0, 1'b0);
    frame("txdis_f1", 1'b0, 1'b0, 8'hBC, 1'b0, 1'b0);
    chk1("txdis_link_ready", link_ready, 1'b1);
    repeat (3) tick();
    tx_enable = 1'b1;
    repeat (4) tick();
    chk1("txen_pre_gnt1", gnt1, 1'b0);
    tick();
    chk1("txen_gnt1", gnt1, 1'b1);
    chk1("txen_gnt0", gnt0, 1'b0);
    chk8("txen_data", data_out, 8'h22);
    chk1("txen_valid", valid_out, 1'b1);
    chk1("txen_lane_sel", lane_sel, 1'b1);
    req1 = 1'b0;

    // Asynchronous reset mid data frame at bit_idx 4.
    repeat (4) tick();
    chk8("mid_bit_idx", {5'd0, bit_idx}, 8'd4);
    chk8("mid_data", data_out, 8'h22);
    #2;
    reset_L = 1'b0;
    #1;
    reset_vals("async");
    @(negedge clk_32f);
    reset_L = 1'b1;
    for (int e = 1; e < 32; e++) begin
      tick();
      chk1("re_link_ready", link_ready, 1'b0);
      chk1("re_valid", valid_out, 1'b0);
    end
    tick();
    chk1("re_e32_link_ready", link_ready, 1'b1);
    chk8("re_e32_data", data_out, 8'hBC);
    chk1("re_e32_valid", valid_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
